// File: rtl/byte_assemble_pkg.sv
// Shared TX/RX framing definitions: state encodings,
// frame geometry and the idle line value.
package byte_assemble_pkg;

  localparam int FRAME_W = 12;

  localparam logic [3:0] BITS_PAR   = 4'd11;
  localparam logic [3:0] BITS_NOPAR = 4'd10;

  localparam logic [FRAME_W-1:0] FRAME_IDLE = 12'hFFF;

  localparam int IDLE_B    = 0;
  localparam int READ_B    = 1;
  localparam int CAPTURE_B = 2;
  localparam int BUILD_B   = 3;
  localparam int LOAD_B    = 4;

  typedef enum logic [4:0] {
    S_IDLE    = 5'b00001,
    S_READ    = 5'b00010,
    S_CAPTURE = 5'b00100,
    S_BUILD   = 5'b01000,
    S_LOAD    = 5'b10000
  } state_e;

  typedef struct packed {
    logic par_en;
    logic odd;
    logic big_end;
  } ctrl_t;

  function automatic logic [7:0] rev8(input logic [7:0] d);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = d[7-i];
    return r;
  endfunction

endpackage

// File: rtl/byte_assemble_parity_gen.sv
// Orders the data byte for transmission and appends the
// parity bit; bits_o[0] is the first data bit on the line.
module parity_gen
  import byte_assemble_pkg::*;
(
  input  logic [7:0] data_i,
  input  logic       en_i,
  input  logic       odd_i,
  input  logic       big_end_i,
  output logic [8:0] bits_o
);

  logic [7:0] ord;
  logic       par;

  // Bit order select and parity (idle-high when disabled)
  always_comb begin
    ord = big_end_i ? rev8(data_i) : data_i;
    par = 1'b1;
    if (en_i) par = odd_i ? ~^data_i : ^data_i;
    bits_o = {par, ord};
  end

endmodule

// File: rtl/byte_assemble.sv
// TX byte assembler: pulls one byte from the TX FIFO and
// builds a start/data/parity/stop frame for the shifter.
module byte_assemble
  import byte_assemble_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  output logic               n_re_o,
  input  logic [7:0]         data_i,
  input  logic               p_empty_i,
  output logic [FRAME_W-1:0] frame_o,
  output logic [3:0]         bit_num_o,
  output logic               p_load_o,
  input  logic               p_ready_i,
  output logic [4:0]         State_o,
  input  logic               p_ParityEnable_i,
  input  logic               p_OddParity_i,
  input  logic               p_BigEnd_i,
  output logic [15:0]        tx_count_o
);

  state_e state_q, state_d;

  logic [7:0]         data_q, data_d;
  ctrl_t              ctrl_q, ctrl_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [3:0]         bnum_q, bnum_d;
  logic               load_q, load_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [8:0]         pg_bits;

  parity_gen u_pg (
    .data_i    (data_q),
    .en_i      (ctrl_q.par_en),
    .odd_i     (ctrl_q.odd),
    .big_end_i (ctrl_q.big_end),
    .bits_o    (pg_bits)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state: READ/CAPTURE/BUILD run to completion
  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      state_q[IDLE_B]:
        if (!p_empty_i && p_ready_i) state_d = S_READ;
      state_q[READ_B]:    state_d = S_CAPTURE;
      state_q[CAPTURE_B]: state_d = S_BUILD;
      state_q[BUILD_B]:   state_d = S_LOAD;
      state_q[LOAD_B]:
        if (!p_ready_i) state_d = S_IDLE;
      default:            state_d = S_IDLE;
    endcase
  end

  // Datapath next values: latch, build, load strobe, count
  always_comb begin
    data_d  = data_q;
    ctrl_d  = ctrl_q;
    frame_d = frame_q;
    bnum_d  = bnum_q;
    load_d  = 1'b0;
    cnt_d   = cnt_q;
    if (state_q[CAPTURE_B]) begin
      data_d = data_i;
      ctrl_d = '{par_en:  p_ParityEnable_i,
                 odd:     p_OddParity_i,
                 big_end: p_BigEnd_i};
    end
    if (state_q[BUILD_B]) begin
      frame_d = {2'b11, pg_bits, 1'b0};
      bnum_d  = ctrl_q.par_en ? BITS_PAR : BITS_NOPAR;
      load_d  = 1'b1;
      cnt_d   = cnt_q + 16'd1;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      data_q  <= '0;
      ctrl_q  <= '0;
      frame_q <= FRAME_IDLE;
      bnum_q  <= '0;
      load_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
      frame_q <= frame_d;
      bnum_q  <= bnum_d;
      load_q  <= load_d;
      cnt_q   <= cnt_d;
    end
  end

  assign n_re_o     = ~state_q[READ_B];
  assign State_o    = state_q;
  assign frame_o    = frame_q;
  assign bit_num_o  = bnum_q;
  assign p_load_o   = load_q;
  assign tx_count_o = cnt_q;

endmodule

// File: tb/tb_byte_assemble.sv
// Directed bench for byte_assemble: reset, idle, frame
// formats, held ready, reset mid-frame, counter wrap.
module tb_byte_assemble;

  logic        clk;
  logic        rst;
  logic        n_re_o;
  logic [7:0]  data_i;
  logic        p_empty_i;
  logic [11:0] frame_o;
  logic [3:0]  bit_num_o;
  logic        p_load_o;
  logic        p_ready_i;
  logic [4:0]  State_o;
  logic        pe_i, odd_i, be_i;
  logic [15:0] tx_count_o;

  int n_cmp = 0;
  int n_err = 0;

  byte_assemble dut (
    .clk              (clk),
    .rst              (rst),
    .n_re_o           (n_re_o),
    .data_i           (data_i),
    .p_empty_i        (p_empty_i),
    .frame_o          (frame_o),
    .bit_num_o        (bit_num_o),
    .p_load_o         (p_load_o),
    .p_ready_i        (p_ready_i),
    .State_o          (State_o),
    .p_ParityEnable_i (pe_i),
    .p_OddParity_i    (odd_i),
    .p_BigEnd_i       (be_i),
    .tx_count_o       (tx_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One frame request; observations returned for inline checks.
  // Negedge c=1 is READ, c=4 is the first LOAD cycle.
  task automatic do_frame(
    input  logic [7:0]  d,
    input  logic        pe, od, be,
    input  int          hold,
    output int          reads,
    output int          loads,
    output int          lat,
    output logic [11:0] fr,
    output logic [3:0]  bn,
    output logic [11:0] fr_after
  );
    @(negedge clk);
    data_i = d; pe_i = pe; odd_i = od; be_i = be;
    p_ready_i = 1'b1; p_empty_i = 1'b0;
    reads = 0; loads = 0; lat = -1;
    fr = '0; bn = '0; fr_after = '0;
    for (int c = 1; c <= 6 + hold; c++) begin
      @(negedge clk);
      if (!n_re_o) reads++;
      if (p_load_o) begin
        loads++;
        if (lat < 0) lat = c;
      end
      if (c == 1) p_empty_i = 1'b1;
      if (c == 3) begin
        data_i = ~d; pe_i = ~pe; odd_i = ~od; be_i = ~be;
      end
      if (c == 3 + hold) p_ready_i = 1'b0;
      if (c == 4) begin fr = frame_o; bn = bit_num_o; end
    end
    fr_after = frame_o;
    p_ready_i = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (State_o !== 5'b00001) begin n_err++;
      $display("FAIL reset_state got=%b exp=00001", State_o); end
    n_cmp++; if (n_re_o !== 1'b1) begin n_err++;
      $display("FAIL reset_nre got=%b exp=1", n_re_o); end
    n_cmp++; if (p_load_o !== 1'b0) begin n_err++;
      $display("FAIL reset_load got=%b exp=0", p_load_o); end
    n_cmp++; if (frame_o !== 12'hFFF) begin n_err++;
      $display("FAIL reset_frame got=%h exp=fff", frame_o); end
    n_cmp++; if (bit_num_o !== 4'd0) begin n_err++;
      $display("FAIL reset_bitnum got=%0d exp=0", bit_num_o); end
    n_cmp++; if (tx_count_o !== 16'd0) begin n_err++;
      $display("FAIL reset_count got=%h exp=0", tx_count_o); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_empty_idle;
    int bad_re, bad_st, bad_ld;
    bad_re = 0; bad_st = 0; bad_ld = 0;
    p_empty_i = 1'b1; p_ready_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (n_re_o !== 1'b1) bad_re++;
      if (State_o !== 5'b00001) bad_st++;
      if (p_load_o !== 1'b0) bad_ld++;
    end
    n_cmp++; if (bad_re != 0) begin n_err++;
      $display("FAIL empty_nre bad_cycles=%0d exp=0", bad_re); end
    n_cmp++; if (bad_st != 0) begin n_err++;
      $display("FAIL empty_state bad_cycles=%0d exp=0", bad_st); end
    n_cmp++; if (bad_ld != 0) begin n_err++;
      $display("FAIL empty_load bad_cycles=%0d exp=0", bad_ld); end
  endtask

  task automatic test_timing;
    logic [4:0] st;
    @(negedge clk);
    data_i = 8'h3C; pe_i = 0; odd_i = 0; be_i = 0;
    p_empty_i = 1'b0; p_ready_i = 1'b1;
    @(negedge clk);
    st = State_o;
    n_cmp++; if (n_re_o !== 1'b0) begin n_err++;
      $display("FAIL read_nre got=%b exp=0", n_re_o); end
    n_cmp++; if (st !== 5'b00010) begin n_err++;
      $display("FAIL read_state got=%b exp=00010", st); end
    p_empty_i = 1'b1;
    @(negedge clk);
    n_cmp++; if (State_o !== 5'b00100 || n_re_o !== 1'b1) begin
      n_err++;
      $display("FAIL capture_state got=%b/%b exp=00100/1",
               State_o, n_re_o); end
    @(negedge clk);
    n_cmp++; if (State_o !== 5'b01000) begin n_err++;
      $display("FAIL build_state got=%b exp=01000", State_o); end
    @(negedge clk);
    n_cmp++; if (State_o !== 5'b10000 || p_load_o !== 1'b1) begin
      n_err++;
      $display("FAIL load_state got=%b/%b exp=10000/1",
               State_o, p_load_o); end
    p_ready_i = 1'b0;
    @(negedge clk);
    n_cmp++; if (State_o !== 5'b00001 || p_load_o !== 1'b0) begin
      n_err++;
      $display("FAIL back_idle got=%b/%b exp=00001/0",
               State_o, p_load_o); end
    p_ready_i = 1'b1;
  endtask

  task automatic test_lsb_noparity;
    int r, l, lat; logic [11:0] f, fa; logic [3:0] b;
    logic [15:0] c0;
    c0 = tx_count_o;
    do_frame(8'hA5, 0, 0, 0, 1, r, l, lat, f, b, fa);
    n_cmp++; if (f !== 12'hF4A) begin n_err++;
      $display("FAIL a5_frame got=%h exp=f4a", f); end
    n_cmp++; if (b !== 4'd10) begin n_err++;
      $display("FAIL a5_bitnum got=%0d exp=10", b); end
    n_cmp++; if (lat !== 4) begin n_err++;
      $display("FAIL a5_latency got=%0d exp=4", lat); end
    n_cmp++; if (r !== 1 || l !== 1) begin n_err++;
      $display("FAIL a5_counts reads=%0d loads=%0d exp=1/1", r, l);
    end
    n_cmp++; if (fa !== 12'hF4A) begin n_err++;
      $display("FAIL a5_hold got=%h exp=f4a", fa); end
    n_cmp++; if (tx_count_o !== c0 + 16'd1) begin n_err++;
      $display("FAIL a5_count got=%h exp=%h", tx_count_o,
               c0 + 16'd1); end
  endtask

  task automatic test_msb_parity;
    int r, l, lat; logic [11:0] f, fa; logic [3:0] b;
    do_frame(8'h01, 1, 0, 1, 1, r, l, lat, f, b, fa);
    n_cmp++; if (f !== 12'hF00) begin n_err++;
      $display("FAIL even_msb_frame got=%h exp=f00", f); end
    n_cmp++; if (b !== 4'd11) begin n_err++;
      $display("FAIL even_msb_bitnum got=%0d exp=11", b); end
    do_frame(8'h01, 1, 1, 1, 1, r, l, lat, f, b, fa);
    n_cmp++; if (f !== 12'hD00) begin n_err++;
      $display("FAIL odd_msb_frame got=%h exp=d00", f); end
    n_cmp++; if (b !== 4'd11) begin n_err++;
      $display("FAIL odd_msb_bitnum got=%0d exp=11", b); end
    do_frame(8'hA5, 1, 0, 0, 1, r, l, lat, f, b, fa);
    n_cmp++; if (f !== 12'hD4A) begin n_err++;
      $display("FAIL even_lsb_frame got=%h exp=d4a", f); end
    do_frame(8'h80, 1, 1, 0, 1, r, l, lat, f, b, fa);
    n_cmp++; if (f !== 12'hD00) begin n_err++;
      $display("FAIL odd_80_frame got=%h exp=d00", f); end
  endtask

  task automatic test_ready_held;
    int r, l, lat; logic [11:0] f, fa; logic [3:0] b;
    logic [15:0] c0;
    c0 = tx_count_o;
    do_frame(8'h5A, 0, 0, 1, 3, r, l, lat, f, b, fa);
    n_cmp++; if (l !== 1) begin n_err++;
      $display("FAIL held_loads got=%0d exp=1", l); end
    n_cmp++; if (r !== 1) begin n_err++;
      $display("FAIL held_reads got=%0d exp=1", r); end
    n_cmp++; if (tx_count_o !== c0 + 16'd1) begin n_err++;
      $display("FAIL held_count got=%h exp=%h", tx_count_o,
               c0 + 16'd1); end
    n_cmp++; if (f !== 12'hEB4) begin n_err++;
      $display("FAIL held_frame got=%h exp=eb4", f); end
  endtask

  task automatic test_reset_in_build;
    int loads;
    loads = 0;
    @(negedge clk);
    data_i = 8'h77; pe_i = 1; odd_i = 0; be_i = 0;
    p_empty_i = 1'b0; p_ready_i = 1'b1;
    repeat (2) @(negedge clk);
    p_empty_i = 1'b1;
    @(negedge clk);
    n_cmp++; if (State_o !== 5'b01000) begin n_err++;
      $display("FAIL rb_build got=%b exp=01000", State_o); end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    n_cmp++; if (State_o !== 5'b00001) begin n_err++;
      $display("FAIL rb_state got=%b exp=00001", State_o); end
    n_cmp++; if (frame_o !== 12'hFFF) begin n_err++;
      $display("FAIL rb_frame got=%h exp=fff", frame_o); end
    n_cmp++; if (tx_count_o !== 16'd0) begin n_err++;
      $display("FAIL rb_count got=%h exp=0", tx_count_o); end
    if (p_load_o) loads++;
    repeat (5) begin
      @(negedge clk);
      if (p_load_o) loads++;
    end
    n_cmp++; if (loads != 0) begin n_err++;
      $display("FAIL rb_noload got=%0d exp=0", loads); end
  endtask

  task automatic test_wrap;
    int r, l, lat; logic [11:0] f, fa; logic [3:0] b;
    @(negedge clk);
    force dut.cnt_q = 16'hFFFF;
    @(posedge clk);
    #1;
    release dut.cnt_q;
    @(negedge clk);
    n_cmp++; if (tx_count_o !== 16'hFFFF) begin n_err++;
      $display("FAIL wrap_preset got=%h exp=ffff", tx_count_o); end
    do_frame(8'hC3, 0, 0, 0, 1, r, l, lat, f, b, fa);
    n_cmp++; if (tx_count_o !== 16'h0000) begin n_err++;
      $display("FAIL wrap_count got=%h exp=0000", tx_count_o); end
  endtask

  initial begin
    rst = 1'b0; data_i = '0; p_empty_i = 1'b1;
    p_ready_i = 1'b1; pe_i = 0; odd_i = 0; be_i = 0;
    test_reset;
    test_empty_idle;
    test_timing;
    test_lsb_noparity;
    test_msb_parity;
    test_ready_held;
    test_reset_in_build;
    test_wrap;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
